// File: rtl/alu_seq_shift_right_if.sv
// Request/response bundle for the sequential right-shift unit.
// The requester uses master; the shift unit uses slave.
interface alu_seq_shift_right_if #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [SHAMT_W-1:0] Shift;
  logic               Arith;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   Answer;

  modport master (
    output in_valid, A, Shift, Arith, out_ready,
    input  in_ready, out_valid, Answer
  );

  modport slave (
    input  in_valid, A, Shift, Arith, out_ready,
    output in_ready, out_valid, Answer
  );
endinterface

// File: rtl/alu_seq_shift_right.sv
// Multi-cycle logical/arithmetic right shifter, STEP bits per cycle; result after ceil(Shift/STEP) edges.
// Accepts only in IDLE (in_ready low while busy); the result is held in DONE until out_ready.
module alu_seq_shift_right #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_seq_shift_right_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W+1)'(STEP);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   work, work_nxt;
  logic [SHAMT_W-1:0] rem, rem_nxt, k;
  logic               fill, fill_nxt;
  logic               out_valid_q;
  logic [WIDTH:0]     shifted;

  // The fill bit rides above the MSB so an arithmetic shift replicates it into the top k bits.
  always_comb begin
    k       = ({1'b0, rem} < STEP_W) ? rem : STEP_W[SHAMT_W-1:0];
    shifted = $signed({fill, work}) >>> k;
  end

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    rem_nxt   = rem;
    fill_nxt  = fill;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          work_nxt  = bus.A;
          rem_nxt   = bus.Shift;
          fill_nxt  = bus.Arith & bus.A[WIDTH-1];
          state_nxt = (bus.Shift == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_nxt = shifted[WIDTH-1:0];
        rem_nxt  = rem - k;
        if (rem_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      work        <= '0;
      rem         <= '0;
      fill        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      work        <= work_nxt;
      rem         <= rem_nxt;
      fill        <= fill_nxt;
      out_valid_q <= (state_nxt == DONE);
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.Answer    = work;
endmodule

// File: tb/tb_alu_seq_shift_right.sv
// Scoreboard bench for the sequential right shifter: STEP=1 and STEP=4 instances side by side.
module tb_alu_seq_shift_right;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_shift_right_if #(.WIDTH(16)) b1 ();
  alu_seq_shift_right_if #(.WIDTH(16)) b4 ();

  alu_seq_shift_right #(.WIDTH(16), .STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  alu_seq_shift_right #(.WIDTH(16), .STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int          lat_q[$];

  function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] sh, input logic ar);
    if (ar) model = 16'($signed(a) >>> sh);
    else    model = a >> sh;
  endfunction

  function automatic int model_lat(input bit sel, input logic [3:0] sh);
    int step;
    step = sel ? 4 : 1;
    model_lat = (int'(sh) + step - 1) / step;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit sel, input logic v, input logic [15:0] a,
                         input logic [3:0] sh, input logic ar);
    if (sel) begin b4.in_valid = v; b4.A = a; b4.Shift = sh; b4.Arith = ar; end
    else     begin b1.in_valid = v; b1.A = a; b1.Shift = sh; b1.Arith = ar; end
  endtask

  task automatic set_ordy(input bit sel, input logic r);
    if (sel) b4.out_ready = r;
    else     b1.out_ready = r;
  endtask

  task automatic get_out(input bit sel, output logic r, output logic v, output logic [15:0] ans);
    if (sel) begin r = b4.in_ready; v = b4.out_valid; ans = b4.Answer; end
    else     begin r = b1.in_ready; v = b1.out_valid; ans = b1.Answer; end
  endtask

  // Drives one request, counts edges after the accepting edge until out_valid, then consumes it.
  task automatic run_op(input bit sel, input logic [15:0] a, input logic [3:0] sh, input logic ar,
                        output logic [15:0] ans, output int lat, output bit ok);
    logic r, v;
    logic [15:0] an;
    ok = 1'b0; lat = -1; ans = 16'hxxxx;
    set_ordy(sel, 1'b1);
    set_req(sel, 1'b1, a, sh, ar);
    get_out(sel, r, v, an);
    for (int i = 0; i < 20 && !r; i++) begin tick(); get_out(sel, r, v, an); end
    if (r) begin
      tick();
      set_req(sel, 1'b0, ~a, ~sh, ~ar);
      lat = 0;
      get_out(sel, r, v, an);
      while (!v && lat < 40) begin tick(); lat++; get_out(sel, r, v, an); end
      if (v) begin ok = 1'b1; ans = an; end
      tick();
    end
  endtask

  task automatic test_reset();
    logic r, v, seen;
    logic [15:0] an;
    rst_n = 1'b0;
    set_ordy(0, 1'b0); set_ordy(1, 1'b0);
    set_req(0, 1'b1, 16'h1234, 4'd3, 1'b0);
    set_req(1, 1'b1, 16'h1234, 4'd3, 1'b0);
    tick(); tick();
    get_out(0, r, v, an);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", v); end
    checks++; if (an !== 16'h0000) begin errors++; $display("FAIL rst_answer got %h want 0000", an); end
    rst_n = 1'b1;
    set_req(0, 1'b0, 16'h0, 4'd0, 1'b0);
    set_req(1, 1'b0, 16'h0, 4'd0, 1'b0);
    tick();
    get_out(0, r, v, an);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", r); end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin get_out(0, r, v, an); seen |= v; tick(); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_accept out_valid seen %b want 0", seen); end
  endtask

  task automatic test_logical();
    logic [15:0] ta[3] = '{16'hF000, 16'h1234, 16'h8000};
    logic [3:0]  ts[3] = '{4'd4, 4'd1, 4'd15};
    logic [15:0] ans, e;
    int lat, el;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(ta[i], ts[i], 1'b0));
      lat_q.push_back(model_lat(0, ts[i]));
      run_op(0, ta[i], ts[i], 1'b0, ans, lat, ok);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL logical_timeout[%0d] no out_valid", i); end
      checks++; if (ans !== e) begin errors++; $display("FAIL logical_answer[%0d] got %h want %h", i, ans, e); end
      checks++; if (lat !== el) begin errors++; $display("FAIL logical_latency[%0d] got %0d want %0d", i, lat, el); end
    end
  endtask

  task automatic test_arith();
    logic [15:0] ta[4] = '{16'h8001, 16'h8001, 16'h7FFF, 16'h8000};
    logic [3:0]  ts[4] = '{4'd15, 4'd15, 4'd15, 4'd4};
    logic        tr[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] ans, e;
    int lat;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model(ta[i], ts[i], tr[i]));
      run_op(0, ta[i], ts[i], tr[i], ans, lat, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || ans !== e) begin errors++; $display("FAIL arith_answer[%0d] got %h want %h", i, ans, e); end
    end
  endtask

  task automatic test_zero_shift();
    logic [15:0] ans, e;
    int lat;
    bit ok;
    exp_q.push_back(16'd10);
    run_op(0, 16'd10, 4'd0, 1'b0, ans, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || ans !== e) begin errors++; $display("FAIL zero_answer got %h want %h", ans, e); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL zero_latency got %0d want 0", lat); end
    exp_q.push_back(16'h8001);
    run_op(0, 16'h8001, 4'd0, 1'b1, ans, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || ans !== e) begin errors++; $display("FAIL zero_arith_answer got %h want %h", ans, e); end
  endtask

  task automatic test_backpressure();
    logic r, v;
    logic [15:0] an, e;
    int n;
    set_ordy(0, 1'b0);
    set_req(0, 1'b1, 16'h00F0, 4'd2, 1'b0);
    exp_q.push_back(model(16'h00F0, 4'd2, 1'b0));
    tick();
    set_req(0, 1'b1, 16'h4000, 4'd1, 1'b1);
    exp_q.push_back(model(16'h4000, 4'd1, 1'b1));
    n = 0; get_out(0, r, v, an);
    while (!v && n < 20) begin tick(); n++; get_out(0, r, v, an); end
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      get_out(0, r, v, an);
      checks++;
      if (v !== 1'b1 || an !== e || r !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b ans=%h rdy=%b want v=1 ans=%h rdy=0", i, v, an, r, e);
      end
      tick();
    end
    set_ordy(0, 1'b1);
    tick();
    get_out(0, r, v, an);
    checks++; if (v !== 1'b0 || r !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", v, r); end
    tick();
    set_req(0, 1'b0, 16'h0, 4'd0, 1'b0);
    get_out(0, r, v, an);
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL bp_pending_accept in_ready got %b want 0", r); end
    n = 0;
    while (!v && n < 20) begin tick(); n++; get_out(0, r, v, an); end
    e = exp_q.pop_front();
    checks++; if (v !== 1'b1 || an !== e || n !== 1) begin
      errors++; $display("FAIL bp_pending_result got ans=%h lat=%0d want ans=%h lat=1", an, n, e);
    end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    logic r, v, seen;
    logic [15:0] an;
    set_ordy(0, 1'b1);
    set_req(0, 1'b1, 16'hFFFF, 4'd8, 1'b0);
    tick();
    set_req(0, 1'b0, 16'h0, 4'd0, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    get_out(0, r, v, an);
    checks++; if (an !== 16'h0000 || r !== 1'b1) begin errors++; $display("FAIL midrst_state got ans=%h rdy=%b want 0000/1", an, r); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin get_out(0, r, v, an); seen |= v; tick(); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_out_valid seen %b want 0", seen); end
  endtask

  task automatic test_step4();
    logic [15:0] ta[4] = '{16'h8001, 16'hF000, 16'h1234, 16'h00AA};
    logic [3:0]  ts[4] = '{4'd15, 4'd4, 4'd5, 4'd0};
    logic        tr[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] ans, e;
    int lat, el;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model(ta[i], ts[i], tr[i]));
      lat_q.push_back(model_lat(1, ts[i]));
      run_op(1, ta[i], ts[i], tr[i], ans, lat, ok);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (!ok || ans !== e) begin errors++; $display("FAIL step4_answer[%0d] got %h want %h", i, ans, e); end
      checks++; if (lat !== el) begin errors++; $display("FAIL step4_latency[%0d] got %0d want %0d", i, lat, el); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, ans, e;
    logic [3:0] sh;
    logic ar;
    bit sel, ok;
    int lat, el;
    for (int i = 0; i < 24; i++) begin
      sel = i[0];
      a  = 16'($urandom);
      sh = 4'($urandom_range(0, 15));
      ar = 1'($urandom_range(0, 1));
      exp_q.push_back(model(a, sh, ar));
      lat_q.push_back(model_lat(sel, sh));
      run_op(sel, a, sh, ar, ans, lat, ok);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      checks++;
      if (!ok || ans !== e || lat !== el) begin
        errors++; $display("FAIL b2b[%0d] step=%0d A=%h sh=%0d ar=%b got %h lat %0d want %h lat %0d",
                           i, sel ? 4 : 1, a, sh, ar, ans, lat, e, el);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_req(0, 1'b0, 16'h0, 4'd0, 1'b0);
    set_req(1, 1'b0, 16'h0, 4'd0, 1'b0);
    set_ordy(0, 1'b0); set_ordy(1, 1'b0);
    rst_n = 1'b0;
    test_reset();
    test_logical();
    test_arith();
    test_zero_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_step4();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
